bus_round_robin_arbiter: RTL and testbench

Round-robin arbiter sharing the single shared-bus master port among up to `NUM_MASTERS` bus masters: DMA controller, CPU data path, camera interface and similar. It samples each master's one-bit request, issues a registered one-hot grant and holds it for the whole bus transaction, which spans from `begin_transaction` to `end_transaction`. A watchdog forcibly closes any transaction that stalls, so a hung master or slave cannot lock the bus.

---
 rtl/bus_arb_pkg.sv | 23 ++
 rtl/rr_priority_select.sv | 41 ++++
 rtl/bus_round_robin_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_round_robin_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the shared-bus round-robin arbiter.
// Holds the FSM encoding, sizing limits and default watchdog timeouts.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_BUSY    = 2'd2,
    ARB_ABORT   = 2'd3
  } arb_state_t;

  localparam int MAX_MASTERS           = 8;
  localparam int IDX_W                 = 3;
  localparam int CNT_W                 = 16;
  localparam int DEFAULT_BEGIN_TIMEOUT = 16;
  localparam int DEFAULT_XFER_TIMEOUT  = 1024;

  // Round-robin successor of a master index, wrapping at n.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: rotate requests by the pointer, take the
// lowest set bit, then map the result back to an absolute master index.
module rr_priority_select
  import bus_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_request,
  input  logic [IDX_W-1:0] i_pointer,
  output logic [N-1:0]     o_winner,
  output logic [IDX_W-1:0] o_index,
  output logic             o_valid
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [N-1:0]     w_rotated;
  logic [IDX_W-1:0] w_rot_idx;
  logic [IDX_W:0]   w_sum;

  // Bit k of the rotated vector is master (pointer + k) mod N.
  assign w_rotated = N'({i_request, i_request} >> i_pointer);

  always_comb begin
    w_rot_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        w_rot_idx = IDX_W'(k);
      end
    end
  end

  assign w_sum   = {1'b0, w_rot_idx} + {1'b0, i_pointer};
  assign o_index = (w_sum >= N_W) ? IDX_W'(w_sum - N_W) : IDX_W'(w_sum);
  assign o_valid = |i_request;

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign o_winner[gi] = o_valid && (o_index == IDX_W'(gi));
  end

endmodule

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin owner of the shared bus master port, with a watchdog that
// releases a grant which never begins or a transfer that never ends.
module bus_round_robin_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS   = 4,
  parameter int BEGIN_TIMEOUT = DEFAULT_BEGIN_TIMEOUT,
  parameter int XFER_TIMEOUT  = DEFAULT_XFER_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   begin_transaction_in,
  input  logic                   end_transaction_in,
  output logic                   end_transaction_out,
  output logic                   bus_error_out,
  output logic [IDX_W-1:0]       active_master,
  output logic                   bus_idle
);

  localparam logic [CNT_W-1:0] BEGIN_LAST = CNT_W'(BEGIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

  arb_state_t             r_state, w_state_next;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
  logic [IDX_W-1:0]       r_ptr, w_ptr_next;
  logic [CNT_W-1:0]       r_count, w_count_next;
  logic [IDX_W-1:0]       r_active, w_active_next;
  logic                   r_end_out, w_end_out_next;
  logic                   r_bus_error, w_bus_error_next;
  logic                   r_idle, w_idle_next;

  logic [NUM_MASTERS-1:0] w_winner;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_valid;

  rr_priority_select #(
    .N(NUM_MASTERS)
  ) u_select (
    .i_request(request),
    .i_pointer(r_ptr),
    .o_winner (w_winner),
    .o_index  (w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_active    <= '0;
      r_end_out   <= 1'b0;
      r_bus_error <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_ptr       <= w_ptr_next;
      r_count     <= w_count_next;
      r_active    <= w_active_next;
      r_end_out   <= w_end_out_next;
      r_bus_error <= w_bus_error_next;
      r_idle      <= w_idle_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_ptr_next       = r_ptr;
    w_count_next     = r_count;
    w_active_next    = r_active;
    w_end_out_next   = 1'b0;
    w_bus_error_next = 1'b0;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_win_valid) begin
          w_state_next  = ARB_GRANTED;
          w_grant_next  = w_winner;
          w_active_next = w_win_idx;
          w_ptr_next    = next_index(w_win_idx, NUM_MASTERS);
          w_count_next  = '0;
        end
      end
      ARB_GRANTED: begin
        // Begin beats both a dropped request and the timeout in the same cycle.
        if (begin_transaction_in) begin
          w_state_next = ARB_BUSY;
          w_count_next = '0;
        end else if (!(|(r_grant & request)) || (r_count == BEGIN_LAST)) begin
          w_state_next     = ARB_IDLE;
          w_grant_next     = '0;
          w_active_next    = '0;
          w_count_next     = '0;
          w_bus_error_next = |(r_grant & request);
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (end_transaction_in) begin
          w_state_next  = ARB_IDLE;
          w_grant_next  = '0;
          w_active_next = '0;
          w_count_next  = '0;
        end else if (r_count == XFER_LAST) begin
          w_state_next     = ARB_ABORT;
          w_count_next     = '0;
          w_end_out_next   = 1'b1;
          w_bus_error_next = 1'b1;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      ARB_ABORT: begin
        w_state_next  = ARB_IDLE;
        w_grant_next  = '0;
        w_active_next = '0;
        w_count_next  = '0;
      end
      default: begin
        w_state_next  = ARB_IDLE;
        w_grant_next  = '0;
        w_active_next = '0;
        w_count_next  = '0;
      end
    endcase

    w_idle_next = (w_grant_next == '0);
  end

  assign grant               = r_grant;
  assign end_transaction_out = r_end_out;
  assign bus_error_out       = r_bus_error;
  assign active_master       = r_active;
  assign bus_idle            = r_idle;

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_bus_round_robin_arbiter;

  localparam int N  = 4;
  localparam int BT = 16;
  localparam int XT = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic         begin_in, end_in, end_out, bus_err;
  logic [2:0]   active;
  logic         idle;

  always #5 clock = ~clock;

  bus_round_robin_arbiter #(
    .NUM_MASTERS  (N),
    .BEGIN_TIMEOUT(BT),
    .XFER_TIMEOUT (XT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .request             (request),
    .grant               (grant),
    .begin_transaction_in(begin_in),
    .end_transaction_in  (end_in),
    .end_transaction_out (end_out),
    .bus_error_out       (bus_err),
    .active_master       (active),
    .bus_idle            (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: who owns the bus, what it is waiting for, and how long it has held it.
  int m_owner = -1;   // -1 = nobody
  int m_phase = 0;    // 0 awaiting begin, 1 transferring, 2 abort cycle
  int m_age   = 0;    // edges since grant / since begin
  int m_ptr   = 0;    // first master considered at the next contention
  logic [N-1:0] e_grant;
  logic [2:0]   e_active;
  logic         e_idle, e_end, e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit req_bit(input int i);
    return ((request >> i) & 4'b0001) != 4'b0000;
  endfunction

  task automatic release_bus(input string why);
    $display("txn: master %0d released (%s) at cycle %0d", m_owner, why, cyc);
    m_owner = -1;
    m_phase = 0;
    m_age   = 0;
  endtask

  task automatic model_edge();
    e_end = 1'b0;
    e_err = 1'b0;
    if (reset) begin
      m_owner = -1; m_phase = 0; m_age = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && req_bit(idx)) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_ptr   = (m_owner + 1) % N;
        m_phase = 0;
        m_age   = 0;
      end
    end else if (m_phase == 0) begin
      if (begin_in) begin
        m_phase = 1;
        m_age   = 0;
      end else if (!req_bit(m_owner)) begin
        release_bus("request dropped");
      end else begin
        m_age++;
        if (m_age == BT) begin
          release_bus("begin timeout");
          e_err = 1'b1;
        end
      end
    end else if (m_phase == 1) begin
      if (end_in) begin
        release_bus("end");
      end else begin
        m_age++;
        if (m_age == XT) begin
          m_phase = 2;
          e_end   = 1'b1;
          e_err   = 1'b1;
        end
      end
    end else begin
      release_bus("transfer abort");
    end
    e_grant  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_active = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e_idle   = (m_owner < 0);
  endtask

  task automatic compare();
    chk("grant", 32'(grant), 32'(e_grant));
    chk("active_master", 32'(active), 32'(e_active));
    chk("bus_idle", 32'(idle), 32'(e_idle));
    chk("end_transaction_out", 32'(end_out), 32'(e_end));
    chk("bus_error_out", 32'(bus_err), 32'(e_err));
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grant(input string name);
    int c;
    c = 0;
    while (grant == '0 && c < 20) begin
      step();
      c++;
    end
    n_checks++;
    if (grant == '0) begin
      n_fail++;
      $display("FAIL %s: grant still 0 after 20 cycles, expected a grant", name);
    end
  endtask

  initial begin
    int order[5];
    int c;

    reset = 1'b1; request = '0; begin_in = 1'b0; end_in = 1'b0;
    @(negedge clock);
    run(2);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_idle", 32'(idle), 32'h1);
    chk("reset_error", 32'(bus_err), 32'h0);
    reset = 1'b0;
    run(2);

    // Single request: grant one edge after sampling, release one edge after end.
    request = 4'b0010;
    step();
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_active", 32'(active), 32'h1);
    step();
    begin_in = 1'b1; step(); begin_in = 1'b0;
    run(11);
    end_in = 1'b1; request = '0; step(); end_in = 1'b0;
    chk("single_release", 32'(grant), 32'h0);
    chk("single_idle", 32'(idle), 32'h1);
    run(2);

    // Fairness with every master requesting, from a fresh pointer.
    reset = 1'b1; step(); reset = 1'b0;
    request = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant("fair_wait");
      order[t] = int'(active);
      begin_in = 1'b1; step(); begin_in = 1'b0;
      run(2);
      end_in = 1'b1; step(); end_in = 1'b0;
    end
    for (int t = 0; t < 5; t++) chk("fair_order", 32'(order[t]), 32'(t % 4));
    request = '0;
    run(2);

    // Begin timeout: master 2 granted but never begins.
    request = 4'b0100;
    step();
    chk("bto_grant", 32'(grant), 32'h4);
    request = 4'b0100;
    c = 0;
    while (!bus_err && c < 40) begin
      step();
      c++;
      if (c == 1) request = 4'b0100;
    end
    request = '0;
    chk("bto_cycles", 32'(c), 32'd16);
    chk("bto_no_end", 32'(end_out), 32'h0);
    chk("bto_grant_low", 32'(grant), 32'h0);
    run(2);

    // Transfer timeout with a second master queued behind.
    request = 4'b0001;
    wait_grant("xto_wait");
    begin_in = 1'b1; request = 4'b1001; step(); begin_in = 1'b0;
    c = 0;
    while (!end_out && c < 100) begin
      step();
      c++;
    end
    chk("xto_cycles", 32'(c), 32'd32);
    chk("xto_error", 32'(bus_err), 32'h1);
    step();
    chk("xto_end_pulse", 32'(end_out), 32'h0);
    chk("xto_grant_low", 32'(grant), 32'h0);
    step();
    chk("xto_next_grant", 32'(grant), 32'h8);
    request = '0;
    run(2);

    // End arriving on the very cycle the transfer watchdog would fire.
    request = 4'b0001;
    wait_grant("sim_wait");
    begin_in = 1'b1; step(); begin_in = 1'b0;
    run(31);
    end_in = 1'b1; request = '0; step(); end_in = 1'b0;
    chk("sim_no_error", 32'(bus_err), 32'h0);
    chk("sim_no_end_out", 32'(end_out), 32'h0);
    chk("sim_release", 32'(grant), 32'h0);
    run(2);

    // Reset in the middle of a transfer.
    request = 4'b0010;
    wait_grant("rst_wait");
    begin_in = 1'b1; step(); begin_in = 1'b0;
    run(3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    request = 4'b1111;
    step();
    chk("rst_ptr_zero", 32'(grant), 32'h1);
    request = '0;
    run(2);

    // Random traffic: sticky requests, sporadic begins, ends and resets.
    for (int i = 0; i < 3000; i++) begin
      request  = request ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      begin_in = ($urandom_range(0, 3) == 0);
      end_in   = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
